// File: rtl/diff_enc_framer.sv
// diff_enc_framer: DPSK frame assembler (ref bit, sync word, payload) paced by mod_busy.
// Optional payload scrambler: define DIFF_ENC_SCRAMBLE_EN.
`ifndef FRAME_TOTAL_LEN
`define FRAME_TOTAL_LEN 114
`endif

module diff_enc_framer #(
    parameter int                  SYNC_LEN    = 13,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD   = 13'b1111100110101,
    parameter int                  PAYLOAD_LEN = `FRAME_TOTAL_LEN - 1 - SYNC_LEN
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic src_data,
    input  logic src_valid,
    output logic src_ready,
    input  logic mod_busy,
    output logic diff_mod_data,
    output logic diff_mod_valid,
    output logic enc_busy,
    output logic frame_done
);

    typedef enum logic [2:0] {
        IDLE,
        REF,
        SYNC,
        PAYLOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [SYNC_LEN-1:0] SYNC_MSB = SYNC_LEN'(1) << (SYNC_LEN - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        prev_q, prev_d;
    logic        data_d, valid_d, busy_d, done_d;
    logic        sync_bit, sync_last, pay_last, pay_bit;

    // Sync word is walked MSB first by masking with a shifting one-hot.
    assign sync_bit  = |(SYNC_WORD & (SYNC_MSB >> cnt_q));
    assign sync_last = (cnt_q == 16'(SYNC_LEN - 1));
    assign pay_last  = (cnt_q == 16'(PAYLOAD_LEN - 1));
    assign src_ready = (state_q == PAYLOAD);

`ifdef DIFF_ENC_SCRAMBLE_EN
    logic [6:0] scr_q;
    logic       scr_bit;

    assign scr_bit = scr_q[6] ^ scr_q[3];
    assign pay_bit = src_data ^ scr_bit;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            scr_q <= 7'h7F;
        end else if (state_q == SYNC && sync_last) begin
            scr_q <= 7'h7F;
        end else if (state_q == PAYLOAD && src_valid) begin
            scr_q <= {scr_q[5:0], scr_bit};
        end
    end
`else
    assign pay_bit = src_data;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        data_d  = diff_mod_data;
        valid_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (src_valid && !mod_busy) state_d = REF;
            end
            REF: begin
                data_d  = 1'b1;
                prev_d  = 1'b1;
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = SYNC;
            end
            SYNC: begin
                data_d  = sync_bit ^ prev_q;
                prev_d  = sync_bit ^ prev_q;
                valid_d = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (sync_last) begin
                    cnt_d   = '0;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (src_valid) begin
                    data_d  = pay_bit ^ prev_q;
                    prev_d  = pay_bit ^ prev_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    if (pay_last) state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (mod_busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!mod_busy) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            prev_q         <= 1'b1;
            diff_mod_data  <= 1'b0;
            diff_mod_valid <= 1'b0;
            enc_busy       <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prev_q         <= prev_d;
            diff_mod_data  <= data_d;
            diff_mod_valid <= valid_d;
            enc_busy       <= busy_d;
            frame_done     <= done_d;
        end
    end

    // mod must stay idle while a frame is being emitted.
    emit_while_busy_a: assert property (@(posedge sys_clk) disable iff (rst)
        !(mod_busy && (state_q inside {REF, SYNC, PAYLOAD})));

endmodule

// File: tb/tb_diff_enc_framer.sv
// Bench for diff_enc_framer: three instances (small, small+1 payload, defaults)
// checked against a frame-level encoding model plus literal vectors.
`ifndef FRAME_TOTAL_LEN
`define FRAME_TOTAL_LEN 114
`endif

module tb_diff_enc_framer;

    localparam int DEF_PL = `FRAME_TOTAL_LEN - 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];
    logic sv  [3];
    logic sd  [3];
    logic mb  [3];
    logic rdy [3];
    logic dd  [3];
    logic dv  [3];
    logic eb  [3];
    logic fd  [3];

    int          sl  [3] = '{3, 3, 13};
    int          pln [3] = '{4, 5, DEF_PL};
    logic [12:0] sw  [3] = '{13'b101, 13'b101, 13'b1111100110101};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    bit exp_q [3][$];
    bit log_q [3][$];
    int first_v [3];
    int last_v  [3];
    int rise_c  [3];
    int done_c  [3];
    int done_n  [3];
    bit eb_p    [3];

    diff_enc_framer #(.SYNC_LEN(3), .SYNC_WORD(3'b101), .PAYLOAD_LEN(4)) u0 (
        .sys_clk(clk), .rst(rst[0]), .src_data(sd[0]), .src_valid(sv[0]),
        .src_ready(rdy[0]), .mod_busy(mb[0]), .diff_mod_data(dd[0]),
        .diff_mod_valid(dv[0]), .enc_busy(eb[0]), .frame_done(fd[0]));

    diff_enc_framer #(.SYNC_LEN(3), .SYNC_WORD(3'b101), .PAYLOAD_LEN(5)) u1 (
        .sys_clk(clk), .rst(rst[1]), .src_data(sd[1]), .src_valid(sv[1]),
        .src_ready(rdy[1]), .mod_busy(mb[1]), .diff_mod_data(dd[1]),
        .diff_mod_valid(dv[1]), .enc_busy(eb[1]), .frame_done(fd[1]));

    diff_enc_framer u2 (
        .sys_clk(clk), .rst(rst[2]), .src_data(sd[2]), .src_valid(sv[2]),
        .src_ready(rdy[2]), .mod_busy(mb[2]), .diff_mod_data(dd[2]),
        .diff_mod_valid(dv[2]), .enc_busy(eb[2]), .frame_done(fd[2]));

    task automatic check(input string nm, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic int flen(input int k);
        return 1 + sl[k] + pln[k];
    endfunction

    // Frame as the spec defines it: ref 1, then running XOR over sync and payload.
    function automatic void model_push(input int k, input logic [127:0] pl);
        bit p, b;
`ifdef DIFF_ENC_SCRAMBLE_EN
        logic [6:0] s;
        bit o;
        s = 7'h7F;
`endif
        exp_q[k].delete();
        p = 1'b1;
        exp_q[k].push_back(p);
        for (int i = 0; i < sl[k]; i++) begin
            b = sw[k][sl[k]-1-i];
            p = p ^ b;
            exp_q[k].push_back(p);
        end
        for (int i = 0; i < pln[k]; i++) begin
            b = pl[i];
`ifdef DIFF_ENC_SCRAMBLE_EN
            o = s[6] ^ s[3];
            s = {s[5:0], o};
            b = b ^ o;
`endif
            p = p ^ b;
            exp_q[k].push_back(p);
        end
    endfunction

    task automatic arm(input int k);
        log_q[k].delete();
        first_v[k] = -1;
        last_v[k]  = -1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            first_v[k] = -1; last_v[k] = -1; rise_c[k] = -1;
            done_c[k] = -1; done_n[k] = 0; eb_p[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (dv[k] === 1'b1) begin
                    if (exp_q[k].size() == 0) check("spurious_valid", k, 1, 0);
                    else check("stream_bit", k, 32'(dd[k]), 32'(exp_q[k].pop_front()));
                    log_q[k].push_back(dd[k]);
                    if (first_v[k] < 0) first_v[k] = cyc;
                    last_v[k] = cyc;
                end
                if (eb[k] === 1'b1 && !eb_p[k]) rise_c[k] = cyc;
                eb_p[k] = (eb[k] === 1'b1);
                if (fd[k] === 1'b1) begin
                    done_n[k]++;
                    done_c[k] = cyc;
                    check("busy_at_done", k, 32'(eb[k]), 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic run_frame(input int k, input logic [127:0] pl,
                             input int st_after, input int st_len, input int busy_len);
        int c0, t, dn0, cd;
        bit r;
        arm(k);
        model_push(k, pl);
        @(posedge clk); #1;
        c0 = cyc;
        sd[k] = pl[0];
        sv[k] = 1'b1;
        mb[k] = 1'b0;
        for (int i = 0; i < pln[k]; i++) begin
            sd[k] = pl[i];
            t = 0;
            do begin
                @(negedge clk);
                r = rdy[k];
                @(posedge clk); #1;
                t++;
            end while (!r && t < 200);
            if (!r) check("ready_timeout", k, 0, 1);
            if (i == st_after) begin
                sv[k] = 1'b0;
                repeat (st_len) @(posedge clk);
                #1;
                sv[k] = 1'b1;
            end
        end
        sv[k] = 1'b0;
        t = 0;
        while (exp_q[k].size() != 0 && t < 50) begin
            @(posedge clk);
            t++;
        end
        check("drain", k, exp_q[k].size(), 0);
        check("start_latency", k, first_v[k] - c0, 2);
        check("busy_rise", k, rise_c[k] - c0, 1);
        check("frame_len", k, log_q[k].size(), flen(k));
        check("valid_gap", k, (last_v[k] - first_v[k] + 1) - flen(k), st_len);
        check("d0", k, 32'(log_q[k][0]), 1);
        @(negedge clk);
        check("wait_busy_enc", k, 32'(eb[k]), 1);
        check("wait_busy_rdy", k, 32'(rdy[k]), 0);
        dn0 = done_n[k];
        @(posedge clk); #1;
        mb[k] = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1;
        mb[k] = 1'b0;
        cd = cyc;
        t = 0;
        while (done_n[k] == dn0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("done_count", k, done_n[k] - dn0, 1);
        check("done_cycle", k, done_c[k] - cd, 1);
    endtask

    task automatic check_lit(input string nm, input int k,
                             input logic [15:0] lit, input int n);
        int mism;
        mism = 0;
        if (log_q[k].size() != n) mism = 100;
        else for (int j = 0; j < n; j++) if (log_q[k][j] != lit[n-1-j]) mism++;
        check(nm, k, mism, 0);
    endtask

    initial begin
        logic [127:0] pl;
        logic [12:0]  w;
        logic [15:0]  lit;
        int c0, errs;
        bit b;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; sv[k] = 1'b0; sd[k] = 1'b0; mb[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_valid", k, 32'(dv[k]), 0);
            check("rst_data", k, 32'(dd[k]), 0);
            check("rst_busy", k, 32'(eb[k]), 0);
            check("rst_done", k, 32'(fd[k]), 0);
            check("rst_ready", k, 32'(rdy[k]), 0);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        // basic frame, payload 1,1,0,0
        pl = '0; pl[3:0] = 4'b0011;
        lit = 16'b1001_0111;
        run_frame(0, pl, -1, 0, 5);
        check_lit("basic_lit", 0, lit, 8);

        // source stall of 3 cycles after payload bit 2
        run_frame(0, pl, 1, 3, 5);
        check_lit("stall_lit", 0, lit, 8);

        // pacing: busy mod blocks the start
        @(posedge clk); #1;
        mb[0] = 1'b1; sv[0] = 1'b1; sd[0] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("pace_ready", 0, 32'(rdy[0]), 0);
            check("pace_busy", 0, 32'(eb[0]), 0);
        end
        pl = '0; pl[3:0] = 4'b1010;
        run_frame(0, pl, -1, 0, 20);
        pl[3:0] = 4'b0110;
        run_frame(0, pl, -1, 0, 5);

        // reset during sync bit 2
        @(posedge clk); #1;
        arm(0);
        pl[3:0] = 4'b1111;
        model_push(0, pl);
        c0 = cyc;
        sd[0] = 1'b1; sv[0] = 1'b1; mb[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst[0] = 1'b1; sv[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 0, 32'(dv[0]), 0);
        check("mid_rst_data", 0, 32'(dd[0]), 0);
        check("mid_rst_busy", 0, 32'(eb[0]), 0);
        check("mid_rst_done", 0, 32'(fd[0]), 0);
        check("mid_rst_ready", 0, 32'(rdy[0]), 0);
        check("mid_rst_emitted", 0, log_q[0].size(), 3);
        check("mid_rst_cycle", 0, cyc - c0, 5);
        exp_q[0].delete();
        pl[3:0] = 4'b0011;
        run_frame(0, pl, -1, 0, 5);
        check_lit("post_rst_lit", 0, lit, 8);

        // all-zero payload of 5 bits
        pl = '0;
`ifdef DIFF_ENC_SCRAMBLE_EN
        lit = 16'b1_0011_1110;
`else
        lit = 16'b1_0011_1111;
`endif
        run_frame(1, pl, -1, 0, 5);
        check_lit("scr_lit", 1, lit, 9);

        // default parameters, random payload, decoded back
        for (int i = 0; i < 4; i++) pl[i*32 +: 32] = $urandom;
        run_frame(2, pl, -1, 0, 5);
        w = sw[2];
        errs = 0;
        if (log_q[2].size() != flen(2)) errs = 1000;
        else begin
`ifdef DIFF_ENC_SCRAMBLE_EN
            logic [6:0] s;
            bit o;
            s = 7'h7F;
`endif
            for (int j = 1; j <= 13; j++)
                if ((log_q[2][j] ^ log_q[2][j-1]) != w[13-j]) errs++;
            for (int j = 0; j < DEF_PL; j++) begin
                b = pl[j];
`ifdef DIFF_ENC_SCRAMBLE_EN
                o = s[6] ^ s[3];
                s = {s[5:0], o};
                b = b ^ o;
`endif
                if ((log_q[2][14+j] ^ log_q[2][13+j]) != b) errs++;
            end
        end
        check("decode_default", 2, errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
